// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive framer
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    MWAIT = 3'd5
  } rx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam logic [3:0] SAMPLE_TICK     = 4'd7;
  localparam logic [3:0] LAST_TICK       = 4'd15;
  localparam logic [3:0] MAJ_FIRST_TICK  = 4'd6;
  localparam logic [3:0] MAJ_SECOND_TICK = 4'd7;
  localparam logic [3:0] MAJ_DECIDE_TICK = 4'd8;

  function automatic logic [3:0] wls_bits(input logic [1:0] wls);
    return {2'b00, wls} + 4'd5;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/slib_counter.sv
// rtl/slib_counter.sv - generic enabled up/down counter with synchronous clear
module slib_counter #(
  parameter int WIDTH = 4,
  parameter bit DOWN  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLEAR,
  input  logic             ENABLE,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else if (CLEAR) begin
      r_q <= '0;
    end else if (ENABLE) begin
      r_q <= DOWN ? (r_q - ONE) : (r_q + ONE);
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - 16x oversampled serial receive framer (5-8 bits, parity, stop, break)
// Define UART_RX_MAJORITY_EN for 2-of-3 voting over ticks 6/7/8 instead of a single tick-7 sample.
module uart_rx_framer
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       CLEAR,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       SIN,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);

  rx_state_t r_state;
  rx_state_t w_next;

  logic       r_sin_meta;
  logic       r_isin;
  logic [3:0] w_tick_cnt;
  logic       w_cnt_clear;
  logic       w_sample_tick;
  logic       w_sample_bit;
  logic       w_boundary;
  logic       w_cap_data;
  logic       w_cap_par;
  logic       w_finish;
  logic [3:0] w_nbits;
  logic       w_xor;

  logic [7:0] r_data;
  logic [3:0] r_bitcnt;
  logic       r_par;
  logic [7:0] r_dout;
  logic       r_pe;
  logic       r_fe;
  logic       r_bi;
  logic       r_finished;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sin_meta <= 1'b1;
      r_isin     <= 1'b1;
    end else begin
      r_sin_meta <= SIN;
      r_isin     <= r_sin_meta;
    end
  end

  slib_counter #(
    .WIDTH (4),
    .DOWN  (1'b0)
  ) u_tick_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .CLEAR  (w_cnt_clear),
    .ENABLE (RXCLK),
    .Q      (w_tick_cnt)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_votes;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_votes <= 2'b11;
    end else if (RXCLK) begin
      if (w_tick_cnt == MAJ_FIRST_TICK)  r_votes[0] <= r_isin;
      if (w_tick_cnt == MAJ_SECOND_TICK) r_votes[1] <= r_isin;
    end
  end

  assign w_sample_tick = RXCLK && (w_tick_cnt == MAJ_DECIDE_TICK);
  assign w_sample_bit  = maj3(r_votes[0], r_votes[1], r_isin);
`else
  assign w_sample_tick = RXCLK && (w_tick_cnt == SAMPLE_TICK);
  assign w_sample_bit  = r_isin;
`endif

  assign w_boundary = RXCLK && (w_tick_cnt == LAST_TICK);
  assign w_nbits    = wls_bits(WLS);
  assign w_xor      = ^r_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_clear = 1'b0;
    w_cap_data  = 1'b0;
    w_cap_par   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clear = 1'b1;
        if (!r_isin) w_next = START;
      end
      START: begin
        if (w_sample_tick && w_sample_bit) begin
          w_next      = IDLE;
          w_cnt_clear = 1'b1;
        end else if (w_boundary) begin
          w_next = DATA;
        end
      end
      DATA: begin
        w_cap_data = w_sample_tick;
        if (w_boundary && (r_bitcnt >= w_nbits)) w_next = PEN ? PAR : STOP;
      end
      PAR: begin
        w_cap_par = w_sample_tick;
        if (w_boundary) w_next = STOP;
      end
      STOP: begin
        if (w_sample_tick) begin
          w_finish = 1'b1;
          w_next   = w_sample_bit ? IDLE : MWAIT;
        end
      end
      MWAIT: begin
        // A held-low line (break or FE) must go high before a new start can be seen.
        w_cnt_clear = 1'b1;
        if (r_isin) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (CLEAR) begin
      w_next      = IDLE;
      w_cnt_clear = 1'b1;
      w_cap_data  = 1'b0;
      w_cap_par   = 1'b0;
      w_finish    = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data     <= 8'h00;
      r_bitcnt   <= 4'd0;
      r_par      <= 1'b0;
      r_dout     <= 8'h00;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_bi       <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_finished <= w_finish;
      if (CLEAR || (r_state == IDLE)) begin
        r_data   <= 8'h00;
        r_bitcnt <= 4'd0;
      end else if (w_cap_data && (r_bitcnt < 4'd8)) begin
        r_data[r_bitcnt[2:0]] <= w_sample_bit;
        r_bitcnt              <= r_bitcnt + 4'd1;
      end
      if (w_cap_par) r_par <= w_sample_bit;
      if (w_finish) begin
        r_dout <= r_data;
        r_fe   <= ~w_sample_bit;
        r_bi   <= ~w_sample_bit && (r_data == 8'h00) && (!PEN || !r_par);
        if (!PEN)     r_pe <= 1'b0;
        else if (SP)  r_pe <= (r_par != ~EPS);
        else if (EPS) r_pe <= w_xor ^ r_par;
        else          r_pe <= ~(w_xor ^ r_par);
      end
    end
  end

  assign DOUT       = r_dout;
  assign PE         = r_pe;
  assign FE         = r_fe;
  assign BI         = r_bi;
  assign RXFINISHED = r_finished;

endmodule
